// File: rtl/regfile_banked.sv
// Register file with a live bank, a shadow bank and a small FSM that copies
// one bank to the other one register per cycle (save / restore).
module regfile_banked #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done,
  output logic              shadow_valid,
  output logic              wr_drop,
  output logic              restore_err
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] live_q   [NREGS];
  logic [DATA_W-1:0] shadow_q [NREGS];
  logic              busy_q, busy_d;
  logic              sv_q, sv_d;
  logic              done_q, done_d;
  logic              wr_drop_q, wr_drop_d;
  logic              restore_err_q, restore_err_d;

  logic              zero_en_s;
  logic              wr_acc_s;
  logic              last_idx_s;
  logic              idx_is_zero_s;

  assign zero_en_s     = (ZERO_REG != 0);
  assign wr_acc_s      = we && !busy_q && !(zero_en_s && (waddr == {ADDR_W{1'b0}}));
  assign last_idx_s    = (idx_q == ADDR_W'(NREGS - 1));
  assign idx_is_zero_s = (idx_q == {ADDR_W{1'b0}});

  // Read mux: hardwired zero wins over forwarding, forwarding over storage.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (zero_en_s && (addr == {ADDR_W{1'b0}})) begin
      val = {DATA_W{1'b0}};
    end else if ((BYPASS != 0) && wr_acc_s && (addr == waddr)) begin
      val = wdata;
    end else begin
      val = live_q[addr];
    end
    return val;
  endfunction

  // Combinational read ports
  always_comb begin
    ra_data = read_port(ra_addr);
    rb_data = read_port(rb_addr);
  end

  // Next-state and pulse logic for the save/restore sequencer
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sv_d          = sv_q;
    done_d        = 1'b0;
    restore_err_d = 1'b0;
    wr_drop_d     = we && busy_q;
    case (state_q)
      ST_IDLE: begin
        if (save_req) begin
          state_d = ST_SAVE;
          idx_d   = {ADDR_W{1'b0}};
          sv_d    = 1'b0;
        end else if (restore_req) begin
          if (sv_q) begin
            state_d = ST_RESTORE;
            idx_d   = {ADDR_W{1'b0}};
          end else begin
            restore_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE: begin
        if (last_idx_s) begin
          state_d = ST_IDLE;
          idx_d   = {ADDR_W{1'b0}};
          done_d  = 1'b1;
          sv_d    = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_RESTORE: begin
        if (last_idx_s) begin
          state_d = ST_IDLE;
          idx_d   = {ADDR_W{1'b0}};
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {ADDR_W{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= {ADDR_W{1'b0}};
      busy_q        <= 1'b0;
      sv_q          <= 1'b0;
      done_q        <= 1'b0;
      wr_drop_q     <= 1'b0;
      restore_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      sv_q          <= sv_d;
      done_q        <= done_d;
      wr_drop_q     <= wr_drop_d;
      restore_err_q <= restore_err_d;
    end
  end

  // Live bank: restore copy has the port to itself because writes are dropped while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        live_q[i] <= {DATA_W{1'b0}};
      end
    end else if (state_q == ST_RESTORE) begin
      if (!(zero_en_s && idx_is_zero_s)) begin
        live_q[idx_q] <= shadow_q[idx_q];
      end
    end else if (wr_acc_s) begin
      live_q[waddr] <= wdata;
    end
  end

  // Shadow bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_q[i] <= {DATA_W{1'b0}};
      end
    end else if (state_q == ST_SAVE) begin
      shadow_q[idx_q] <= live_q[idx_q];
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign shadow_valid = sv_q;
  assign wr_drop      = wr_drop_q;
  assign restore_err  = restore_err_q;

endmodule

// File: tb/tb_regfile_banked.sv
// Scoreboard bench: two instances (bypass/no-zero and no-bypass/zero-reg) share stimulus.
module tb_regfile_banked;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [1:0] ra_addr, rb_addr;
  logic       save_req, restore_req;

  logic [7:0] a_ra, a_rb, b_ra, b_rb;
  logic       a_busy, a_done, a_sv, a_drop, a_err;
  logic       b_busy, b_done, b_sv, b_drop, b_err;

  int checks = 0;
  int errors = 0;

  localparam int S_ARA = 0, S_ARB = 1, S_ABUSY = 2, S_ADONE = 3, S_ASV = 4, S_ADROP = 5,
                 S_AERR = 6, S_BRA = 7, S_BRB = 8, S_BBUSY = 9, S_BDONE = 10, S_BSV = 11;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];

  regfile_banked #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_dut_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(a_ra), .rb_data(a_rb),
    .save_req(save_req), .restore_req(restore_req), .busy(a_busy), .done(a_done),
    .shadow_valid(a_sv), .wr_drop(a_drop), .restore_err(a_err)
  );

  regfile_banked #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(b_ra), .rb_data(b_rb),
    .save_req(save_req), .restore_req(restore_req), .busy(b_busy), .done(b_done),
    .shadow_valid(b_sv), .wr_drop(b_drop), .restore_err(b_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_ARA:   return a_ra;
      S_ARB:   return a_rb;
      S_ABUSY: return {7'd0, a_busy};
      S_ADONE: return {7'd0, a_done};
      S_ASV:   return {7'd0, a_sv};
      S_ADROP: return {7'd0, a_drop};
      S_AERR:  return {7'd0, a_err};
      S_BRA:   return b_ra;
      S_BRB:   return b_rb;
      S_BBUSY: return {7'd0, b_busy};
      S_BDONE: return {7'd0, b_done};
      S_BSV:   return {7'd0, b_sv};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] ra, input logic [1:0] rb,
                       input logic sv, input logic rs);
    we = w; waddr = wa; wdata = wd; ra_addr = ra; rb_addr = rb;
    save_req = sv; restore_req = rs;
  endtask

  logic [7:0] wv [4];

  initial begin
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;
    reset = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0, 1'b0);
    repeat (2) cyc();
    reset = 1'b0;
    push_exp("rst_a_ra", S_ARA, 8'h00);   push_exp("rst_a_rb", S_ARB, 8'h00);
    push_exp("rst_busy", S_ABUSY, 8'h00); push_exp("rst_done", S_ADONE, 8'h00);
    push_exp("rst_sv", S_ASV, 8'h00);     push_exp("rst_drop", S_ADROP, 8'h00);
    push_exp("rst_err", S_AERR, 8'h00);   push_exp("rst_b_ra", S_BRA, 8'h00);
    drain();

    // write r0..r3; A forwards the write, B shows the stored (still zero) value
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b1, 2'(i), wv[i], 2'(i), 2'(i), 1'b0, 1'b0);
      push_exp("wr_byp_a", S_ARA, wv[i]);
      push_exp("wr_nobyp_b", S_BRA, 8'h00);
      drain();
    end
    cyc();
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0, 1'b0);
    push_exp("rd_a_r2", S_ARA, 8'h33); push_exp("rd_a_r3", S_ARB, 8'h44);
    push_exp("rd_b_r2", S_BRA, 8'h33); push_exp("rd_b_r3", S_BRB, 8'h44);
    drain();

    cyc();
    drive(1'b1, 2'd1, 8'hA5, 2'd1, 2'd0, 1'b0, 1'b0);
    push_exp("byp_a5_a", S_ARA, 8'hA5); push_exp("nobyp_old_b", S_BRA, 8'h22);
    push_exp("rd_a_r0", S_ARB, 8'h11);  push_exp("zero_b_r0", S_BRB, 8'h00);
    drain();
    cyc();
    drive(1'b1, 2'd0, 8'hFF, 2'd1, 2'd0, 1'b0, 1'b0);
    push_exp("stored_a5_a", S_ARA, 8'hA5); push_exp("stored_a5_b", S_BRA, 8'hA5);
    push_exp("byp_r0_a", S_ARB, 8'hFF);    push_exp("zero_byp_b", S_BRB, 8'h00);
    drain();
    cyc();
    drive(1'b1, 2'd1, 8'h22, 2'd0, 2'd1, 1'b0, 1'b0);
    push_exp("r0_ff_a", S_ARA, 8'hFF); push_exp("r0_zero_b", S_BRA, 8'h00);
    push_exp("byp22_a", S_ARB, 8'h22); push_exp("nobyp_a5_b", S_BRB, 8'hA5);
    drain();

    // restore without a valid shadow
    cyc();
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 1'b0, 1'b1);
    push_exp("pre_err_busy", S_ABUSY, 8'h00); push_exp("r1_a", S_ARA, 8'h22);
    push_exp("r1_b", S_BRA, 8'h22);           push_exp("r3_a", S_ARB, 8'h44);
    drain();
    cyc();
    restore_req = 1'b0;
    push_exp("err_pulse", S_AERR, 8'h01); push_exp("err_busy", S_ABUSY, 8'h00);
    drain();
    cyc();
    push_exp("err_clear", S_AERR, 8'h00); push_exp("err_busy2", S_ABUSY, 8'h00);
    drain();

    // save; write and restore_req during busy must be dropped/ignored
    cyc();
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b1, 1'b0);
    push_exp("sv_idle_busy", S_ABUSY, 8'h00); push_exp("sv_pre", S_ASV, 8'h00);
    drain();
    cyc();
    drive(1'b1, 2'd2, 8'h99, 2'd2, 2'd3, 1'b0, 1'b1);
    push_exp("sv_busy1", S_ABUSY, 8'h01); push_exp("sv_cleared", S_ASV, 8'h00);
    push_exp("drop_nobyp_a", S_ARA, 8'h33); push_exp("drop_b", S_BRA, 8'h33);
    push_exp("sv_busy1_b", S_BBUSY, 8'h01);
    drain();
    cyc();
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0, 1'b0);
    push_exp("sv_busy2", S_ABUSY, 8'h01); push_exp("wr_drop", S_ADROP, 8'h01);
    push_exp("busy_no_err", S_AERR, 8'h00);
    drain();
    cyc();
    push_exp("sv_busy3", S_ABUSY, 8'h01); push_exp("wr_drop_end", S_ADROP, 8'h00);
    push_exp("sv_nodone", S_ADONE, 8'h00);
    drain();
    cyc();
    push_exp("sv_busy4", S_ABUSY, 8'h01);
    drain();
    cyc();
    push_exp("sv_idle", S_ABUSY, 8'h00); push_exp("sv_done", S_ADONE, 8'h01);
    push_exp("sv_valid", S_ASV, 8'h01);  push_exp("dropped_r2", S_ARA, 8'h33);
    push_exp("sv_done_b", S_BDONE, 8'h01); push_exp("sv_valid_b", S_BSV, 8'h01);
    drain();
    cyc();
    push_exp("sv_done_end", S_ADONE, 8'h00); push_exp("sv_no_restart", S_ABUSY, 8'h00);
    drain();

    // clobber r1 and r0, then restore
    cyc();
    drive(1'b1, 2'd1, 8'h00, 2'd1, 2'd1, 1'b0, 1'b0);
    drain();
    cyc();
    drive(1'b1, 2'd0, 8'h00, 2'd1, 2'd1, 1'b0, 1'b0);
    push_exp("clob_r1_a", S_ARA, 8'h00);
    drain();
    cyc();
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1);
    push_exp("rs_pre_busy", S_ABUSY, 8'h00); push_exp("rs_pre_r0", S_ARA, 8'h00);
    push_exp("rs_pre_r1", S_ARB, 8'h00);     push_exp("rs_pre_r1_b", S_BRB, 8'h00);
    drain();
    cyc();
    restore_req = 1'b0;
    push_exp("rs_busy1", S_ABUSY, 8'h01); push_exp("rs_r0_notyet", S_ARA, 8'h00);
    push_exp("rs_r1_notyet", S_ARB, 8'h00); push_exp("rs_sv_kept", S_ASV, 8'h01);
    drain();
    cyc();
    push_exp("rs_r0_done", S_ARA, 8'hFF); push_exp("rs_r1_part", S_ARB, 8'h00);
    push_exp("rs_zero_b", S_BRA, 8'h00);  push_exp("rs_busy2", S_ABUSY, 8'h01);
    drain();
    cyc();
    push_exp("rs_r1_a", S_ARB, 8'h22); push_exp("rs_r1_b", S_BRB, 8'h22);
    push_exp("rs_busy3", S_ABUSY, 8'h01);
    drain();
    cyc();
    push_exp("rs_busy4", S_ABUSY, 8'h01);
    drain();
    cyc();
    push_exp("rs_idle", S_ABUSY, 8'h00); push_exp("rs_done", S_ADONE, 8'h01);
    push_exp("rs_sv", S_ASV, 8'h01);     push_exp("rs_fin_r0", S_ARA, 8'hFF);
    push_exp("rs_fin_r1", S_ARB, 8'h22); push_exp("rs_fin_r0_b", S_BRA, 8'h00);
    push_exp("rs_fin_r1_b", S_BRB, 8'h22);
    drain();
    cyc();
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0, 1'b0);
    push_exp("rs_done_end", S_ADONE, 8'h00); push_exp("rs_r2", S_ARA, 8'h33);
    push_exp("rs_r3", S_ARB, 8'h44);
    drain();

    // reset during the second SAVE cycle
    cyc();
    save_req = 1'b1;
    drain();
    cyc();
    save_req = 1'b0;
    push_exp("ab_busy1", S_ABUSY, 8'h01); push_exp("ab_sv0", S_ASV, 8'h00);
    drain();
    cyc();
    reset = 1'b1;
    push_exp("ab_busy", S_ABUSY, 8'h00); push_exp("ab_sv", S_ASV, 8'h00);
    push_exp("ab_ra", S_ARA, 8'h00);     push_exp("ab_rb", S_ARB, 8'h00);
    push_exp("ab_rb_b", S_BRB, 8'h00);
    drain();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      push_exp("ab_nodone", S_ADONE, 8'h00); push_exp("ab_idle", S_ABUSY, 8'h00);
      push_exp("ab_sv_low", S_ASV, 8'h00);   push_exp("ab_r3", S_ARB, 8'h00);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
